db_mv_ram_ctrl: RTL and testbench
=================================

// Module: db_mv_ram_ctrl
// PURPOSE
//  Sequencer/arbiter for the single-port 64x20 deblocking MV RAM.
//  - Clears the RAM to zero at every LCU start.
//  - Shares the one RAM port between an MV writer (from ME/FME) and an MV reader (the deblocking filter).
//  - Reads win arbitration. Writes are absorbed by a small FIFO, and reads bypass pending writes.
// PARAMETERS
//  ADR_W       6   RAM address width
//  DAT_W       20  MV word width
//  RAM_DEPTH   64  entries swept by the clear sequence
//  FIFO_DEPTH  2   write-buffer entries (>=1)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      asynchronous active-low reset
//  start_i     in   1      LCU start pulse: flush the FIFO, begin the clear
//  busy_o      out  1      1 while clearing
//  clr_done_o  out  1      1-cycle pulse after the last clear write
//  wr_val_i    in   1      write request
//  wr_rdy_o    out  1      write accepted when wr_val_i & wr_rdy_o
//  wr_adr_i    in   ADR_W  write address
//  wr_dat_i    in   DAT_W  write data
//  rd_req_i    in   1      read request
//  rd_rdy_o    out  1      read accepted when rd_req_i & rd_rdy_o
//  rd_adr_i    in   ADR_W  read address
//  rd_val_o    out  1      read data valid, 1 cycle after acceptance
//  rd_dat_o    out  DAT_W  read data
//  ram_cen_o   out  1      RAM chip enable, active low
//  ram_wen_o   out  1      RAM write enable, active low
//  ram_adr_o   out  ADR_W  RAM address
//  ram_wdat_o  out  DAT_W  RAM write data
//  ram_rdat_i  in   DAT_W  RAM read data, valid 1 cycle after cen
// BEHAVIOUR
//  Reset values
//  - State IDLE, FIFO empty, clear counter 0.
//  - rd_val_o=0, clr_done_o=0, busy_o=0, ram_cen_o=1, ram_wen_o=1, ram_adr_o=0, ram_wdat_o=0.
//  FSM states: IDLE, CLR, RUN
//  - IDLE: wr_rdy_o=0, rd_rdy_o=0, RAM idle.
//  - start_i in any state -> CLR, counter=0, FIFO flushed. start_i overrides all else.
//  - CLR: one write per cycle: cen=0, wen=0, adr=counter, wdat=0.
//    - After counter=RAM_DEPTH-1 -> RUN.
//    - clr_done_o pulses in the first RUN cycle.
//    - busy_o=1; both rdy outputs 0.
//  - RUN: rd_rdy_o = ~start_i. wr_rdy_o = ~fifo_full & ~start_i.
//  RAM port priority in RUN (per cycle)
//  - Accepted read: cen=0, wen=1, adr=rd_adr_i.
//  - Else, FIFO not empty: pop the head, cen=0, wen=0.
//  - Else: cen=1.
//  RAM-side outputs are combinational from registered state and the current requests.
//  FIFO
//  - Push and pop in the same cycle are legal when not full.
//  - When full, no push: there is no fall-through.
//  - With FIFO_DEPTH=2, writes stall after 2 consecutive read-occupied cycles.
//  Read latency is exactly 1 cycle: rd_val_o is registered; rd_dat_o is muxed.
//  Bypass
//  - At acceptance, rd_adr_i is compared with all valid FIFO entries and with the entry pushed the same cycle.
//  - On a hit, the youngest matching data is registered and driven on rd_dat_o next cycle.
//  - On a miss, rd_dat_o = ram_rdat_i.
//  Boundaries
//  - start_i with a read in flight: that read's rd_val_o is still delivered.
//  - start_i with pending FIFO writes: the writes are dropped.
//  - Reset mid-clear: back to IDLE; a new start_i is needed.
//  - Address wrap: the clear counter is ADR_W bits and RAM_DEPTH=2^ADR_W, so it wraps to 0 on CLR exit.
//  - Write/read to the same address in the same cycle: the read returns the new data via bypass.
// STRUCTURE
//  - Shared constants go in enc_defines.v: DB_MV_ADR_W, DB_MV_DAT_W, state encodings IDLE/CLR/RUN.
//  - One sub-module, db_mv_wr_fifo: FIFO_DEPTH x (ADR_W+DAT_W) register FIFO with full/empty and per-entry compare outputs.
//  - The FSM, arbitration and bypass mux stay in db_mv_ram_ctrl.
// TESTING
//  - Clear: start_i at cycle 0 -> 64 writes of 0 at adr 0..63, busy_o=1 for 64 cycles, clr_done_o one pulse at cycle 65.
//  - Idle read: after the clear, read adr 17 -> rd_val_o next cycle, rd_dat_o=20'h0.
//  - Bypass: write adr 5 = 20'hABCDE and read adr 5 in the same cycle -> rd_dat_o=20'hABCDE; RAM holds it after the drain.
//  - Backpressure: rd_req_i held 4 cycles while writing adr 1,2,3 -> wr_rdy_o=0 on the 3rd write until the reads stop; all 3 land in order.
//  - Restart: start_i with 2 writes pending -> both dropped, RAM reads 0 at those addresses after the new clear.
//  - Reset mid-clear: rst_n low at counter=30 -> all outputs at reset values, IDLE, no RAM access until start_i.

Source files
------------

// File: rtl/db_mv_ram_ctrl_pkg.sv
// Shared constants and state encoding for the deblocking MV RAM controller.
// Default widths match the 64x20 single-port MV RAM.
package db_mv_ram_ctrl_pkg;

   localparam int DB_MV_ADR_W = 6;
   localparam int DB_MV_DAT_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/db_mv_ram_ctrl_wr_fifo.sv
// Small shift-style write buffer: entry 0 is the oldest, valid entries are packed from index 0.
// Exposes per-entry address compares so the controller can bypass pending writes to reads.
module db_mv_wr_fifo #(
   parameter int ADR_W = 6,
   parameter int DAT_W = 20,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [ADR_W-1:0]             push_adr_i,
   input  logic [DAT_W-1:0]             push_dat_i,
   input  logic                         pop_i,
   input  logic [ADR_W-1:0]             cmp_adr_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [ADR_W-1:0]             head_adr_o,
   output logic [DAT_W-1:0]             head_dat_o,
   output logic [DEPTH-1:0]             hit_o,
   output logic [DEPTH-1:0][DAT_W-1:0]  ent_dat_o
);

   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][ADR_W-1:0]  adr_q, adr_d;
   logic [DEPTH-1:0][DAT_W-1:0]  dat_q, dat_d;
   logic                         placed;

   always_comb begin
      vld_d  = vld_q;
      adr_d  = adr_q;
      dat_d  = dat_q;
      placed = 1'b0;
      if (pop_i) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            vld_d[i] = vld_q[i+1];
            adr_d[i] = adr_q[i+1];
            dat_d[i] = dat_q[i+1];
         end
         vld_d[DEPTH-1] = 1'b0;
      end
      // Push lands in the lowest free slot after the pop has compacted the entries.
      for (int i = 0; i < DEPTH; i++) begin
         if (push_i && !placed && !vld_d[i]) begin
            vld_d[i] = 1'b1;
            adr_d[i] = push_adr_i;
            dat_d[i] = push_dat_i;
            placed   = 1'b1;
         end
      end
      if (flush_i) begin
         vld_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      adr_q <= adr_d;
      dat_q <= dat_d;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         hit_o[i] = vld_q[i] && (adr_q[i] == cmp_adr_i);
      end
   end

   assign full_o     = vld_q[DEPTH-1];
   assign empty_o    = ~vld_q[0];
   assign head_adr_o = adr_q[0];
   assign head_dat_o = dat_q[0];
   assign ent_dat_o  = dat_q;

endmodule

// File: rtl/db_mv_ram_ctrl.sv
// Sequencer/arbiter for the single-port deblocking MV RAM: clears it per LCU, then shares
// the port between the MV reader (priority) and a buffered MV writer, with read bypass.
module db_mv_ram_ctrl
   import db_mv_ram_ctrl_pkg::*;
#(
   parameter int ADR_W      = DB_MV_ADR_W,
   parameter int DAT_W      = DB_MV_DAT_W,
   parameter int RAM_DEPTH  = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              busy_o,
   output logic              clr_done_o,
   input  logic              wr_val_i,
   output logic              wr_rdy_o,
   input  logic [ADR_W-1:0]  wr_adr_i,
   input  logic [DAT_W-1:0]  wr_dat_i,
   input  logic              rd_req_i,
   output logic              rd_rdy_o,
   input  logic [ADR_W-1:0]  rd_adr_i,
   output logic              rd_val_o,
   output logic [DAT_W-1:0]  rd_dat_o,
   output logic              ram_cen_o,
   output logic              ram_wen_o,
   output logic [ADR_W-1:0]  ram_adr_o,
   output logic [DAT_W-1:0]  ram_wdat_o,
   input  logic [DAT_W-1:0]  ram_rdat_i
);

   localparam logic [ADR_W-1:0] CNT_LAST = ADR_W'(RAM_DEPTH - 1);

   state_e                          state_q, state_d;
   logic [ADR_W-1:0]                cnt_q, cnt_d;
   logic                            clr_last;
   logic                            clr_done_q;
   logic                            rd_val_q;
   logic                            hit_q;
   logic                            byp_hit;
   logic [DAT_W-1:0]                byp_dat_q, byp_dat_d;

   logic                            run;
   logic                            rd_acc;
   logic                            wr_push;
   logic                            fifo_pop;
   logic                            push_hit;
   logic                            fifo_full;
   logic                            fifo_empty;
   logic [ADR_W-1:0]                fifo_head_adr;
   logic [DAT_W-1:0]                fifo_head_dat;
   logic [FIFO_DEPTH-1:0]           fifo_hit;
   logic [FIFO_DEPTH-1:0][DAT_W-1:0] fifo_dat;

   assign run      = (state_q == ST_RUN) && !start_i;
   assign rd_rdy_o = run;
   assign wr_rdy_o = run && !fifo_full;
   assign rd_acc   = rd_req_i && run;
   assign wr_push  = wr_val_i && wr_rdy_o;
   assign fifo_pop = run && !rd_acc && !fifo_empty;
   assign push_hit = wr_push && (wr_adr_i == rd_adr_i);

   db_mv_wr_fifo #(
      .ADR_W (ADR_W),
      .DAT_W (DAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (start_i),
      .push_i     (wr_push),
      .push_adr_i (wr_adr_i),
      .push_dat_i (wr_dat_i),
      .pop_i      (fifo_pop),
      .cmp_adr_i  (rd_adr_i),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_adr_o (fifo_head_adr),
      .head_dat_o (fifo_head_dat),
      .hit_o      (fifo_hit),
      .ent_dat_o  (fifo_dat)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_last = 1'b0;
      case (state_q)
         ST_IDLE: ;
         ST_CLR: begin
            cnt_d = cnt_q + ADR_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = ST_RUN;
               clr_last = 1'b1;
            end
         end
         ST_RUN: ;
         default: state_d = ST_IDLE;
      endcase
      if (start_i) begin
         state_d  = ST_CLR;
         cnt_d    = '0;
         clr_last = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
         rd_val_q   <= 1'b0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_done_q <= clr_last;
         rd_val_q   <= rd_acc;
         hit_q      <= rd_acc && byp_hit;
      end
   end

   // A start cycle leaves the RAM untouched; reads beat pending writes otherwise.
   always_comb begin
      ram_cen_o  = 1'b1;
      ram_wen_o  = 1'b1;
      ram_adr_o  = '0;
      ram_wdat_o = '0;
      if (!start_i) begin
         if (state_q == ST_CLR) begin
            ram_cen_o = 1'b0;
            ram_wen_o = 1'b0;
            ram_adr_o = cnt_q;
         end else if (rd_acc) begin
            ram_cen_o = 1'b0;
            ram_adr_o = rd_adr_i;
         end else if (fifo_pop) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_adr_o  = fifo_head_adr;
            ram_wdat_o = fifo_head_dat;
         end
      end
   end

   // Later matches overwrite earlier ones, so the youngest pending write wins.
   always_comb begin
      byp_hit   = 1'b0;
      byp_dat_d = byp_dat_q;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_hit[i]) begin
            byp_hit   = 1'b1;
            byp_dat_d = fifo_dat[i];
         end
      end
      if (push_hit) begin
         byp_hit   = 1'b1;
         byp_dat_d = wr_dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_acc) begin
         byp_dat_q <= byp_dat_d;
      end
   end

   assign busy_o     = (state_q == ST_CLR);
   assign clr_done_o = clr_done_q;
   assign rd_val_o   = rd_val_q;
   assign rd_dat_o   = hit_q ? byp_dat_q : ram_rdat_i;

endmodule

// File: tb/tb_db_mv_ram_ctrl.sv
// Directed bench for db_mv_ram_ctrl with a behavioural 64x20 RAM and a read-data scoreboard.
module tb_db_mv_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        busy_o;
   logic        clr_done_o;
   logic        wr_val_i;
   logic        wr_rdy_o;
   logic [5:0]  wr_adr_i;
   logic [19:0] wr_dat_i;
   logic        rd_req_i;
   logic        rd_rdy_o;
   logic [5:0]  rd_adr_i;
   logic        rd_val_o;
   logic [19:0] rd_dat_o;
   logic        ram_cen_o;
   logic        ram_wen_o;
   logic [5:0]  ram_adr_o;
   logic [19:0] ram_wdat_o;
   logic [19:0] ram_rdat_i;

   logic [19:0] mem [64];
   logic [19:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   db_mv_ram_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .busy_o     (busy_o),
      .clr_done_o (clr_done_o),
      .wr_val_i   (wr_val_i),
      .wr_rdy_o   (wr_rdy_o),
      .wr_adr_i   (wr_adr_i),
      .wr_dat_i   (wr_dat_i),
      .rd_req_i   (rd_req_i),
      .rd_rdy_o   (rd_rdy_o),
      .rd_adr_i   (rd_adr_i),
      .rd_val_o   (rd_val_o),
      .rd_dat_o   (rd_dat_o),
      .ram_cen_o  (ram_cen_o),
      .ram_wen_o  (ram_wen_o),
      .ram_adr_o  (ram_adr_o),
      .ram_wdat_o (ram_wdat_o),
      .ram_rdat_i (ram_rdat_i)
   );

   // Single-port RAM, registered read data
   always @(posedge clk) begin
      if (!ram_cen_o) begin
         if (!ram_wen_o) mem[ram_adr_o] <= ram_wdat_o;
         else            ram_rdat_i     <= mem[ram_adr_o];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every delivered read is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_val_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %h expected no read at %0t", rd_dat_o, $time);
         end else begin
            chk("rd_dat", {12'h0, rd_dat_o}, {12'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start_i  = 1'b0;
      wr_val_i = 1'b0;
      wr_adr_i = '0;
      wr_dat_i = '0;
      rd_req_i = 1'b0;
      rd_adr_i = '0;
   endtask

   task automatic run_clear(input bit full_check);
      start_i = 1'b1;
      smp();
      chk("start_rd_rdy", {31'h0, rd_rdy_o}, 32'h0);
      chk("start_wr_rdy", {31'h0, wr_rdy_o}, 32'h0);
      chk("start_cen", {31'h0, ram_cen_o}, 32'h1);
      step();
      start_i = 1'b0;
      for (int k = 0; k < 64; k++) begin
         smp();
         if (full_check) begin
            chk("clr_cen", {31'h0, ram_cen_o}, 32'h0);
            chk("clr_wen", {31'h0, ram_wen_o}, 32'h0);
            chk("clr_adr", {26'h0, ram_adr_o}, k);
            chk("clr_wdat", {12'h0, ram_wdat_o}, 32'h0);
            chk("clr_busy", {31'h0, busy_o}, 32'h1);
            chk("clr_rdy", {30'h0, rd_rdy_o, wr_rdy_o}, 32'h0);
         end
         chk("clr_done_early", {31'h0, clr_done_o}, 32'h0);
         step();
      end
      smp();
      chk("clr_done", {31'h0, clr_done_o}, 32'h1);
      chk("busy_after_clr", {31'h0, busy_o}, 32'h0);
      chk("rd_rdy_run", {31'h0, rd_rdy_o}, 32'h1);
      step();
      smp();
      chk("clr_done_pulse", {31'h0, clr_done_o}, 32'h0);
      step();
   endtask

   task automatic do_read(input logic [5:0] adr, input logic [19:0] exp);
      rd_req_i = 1'b1;
      rd_adr_i = adr;
      exp_q.push_back(exp);
      step();
      rd_req_i = 1'b0;
      step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
      chk({tag, "_clr_done"}, {31'h0, clr_done_o}, 32'h0);
      chk({tag, "_rd_val"}, {31'h0, rd_val_o}, 32'h0);
      chk({tag, "_cen"}, {31'h0, ram_cen_o}, 32'h1);
      chk({tag, "_wen"}, {31'h0, ram_wen_o}, 32'h1);
      chk({tag, "_adr"}, {26'h0, ram_adr_o}, 32'h0);
      chk({tag, "_wdat"}, {12'h0, ram_wdat_o}, 32'h0);
      chk({tag, "_rdy"}, {30'h0, rd_rdy_o, wr_rdy_o}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 20'hF0000 | 20'(i);
      ram_rdat_i = 20'h0;
      rst_n      = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      smp();
      chk_reset_outputs("rst");
      step();
      rst_n = 1'b1;
      step();
      smp();
      chk_reset_outputs("idle");
      step();

      // Initial clear sweep
      run_clear(1'b1);

      // Read of a cleared location
      do_read(6'd17, 20'h0);

      // Same-cycle write and read of one address: bypass, then the drained value from RAM
      wr_val_i = 1'b1; wr_adr_i = 6'd5; wr_dat_i = 20'hABCDE;
      rd_req_i = 1'b1; rd_adr_i = 6'd5;
      exp_q.push_back(20'hABCDE);
      smp();
      chk("byp_wr_rdy", {31'h0, wr_rdy_o}, 32'h1);
      chk("byp_rd_wen", {31'h0, ram_wen_o}, 32'h1);
      step();
      idle_inputs();
      smp();
      chk("byp_drain_wen", {31'h0, ram_wen_o}, 32'h0);
      chk("byp_drain_wdat", {12'h0, ram_wdat_o}, 32'hABCDE);
      step();
      do_read(6'd5, 20'hABCDE);
      do_read(6'd4, 20'h0);

      // Back-to-back reads starve the port; writes fill the buffer then stall
      wr_val_i = 1'b1; wr_adr_i = 6'd1; wr_dat_i = 20'h11111;
      rd_req_i = 1'b1; rd_adr_i = 6'd10; exp_q.push_back(20'h0);
      smp(); chk("bp_c0_wr_rdy", {31'h0, wr_rdy_o}, 32'h1); step();
      wr_adr_i = 6'd2; wr_dat_i = 20'h22222;
      rd_adr_i = 6'd11; exp_q.push_back(20'h0);
      smp(); chk("bp_c1_wr_rdy", {31'h0, wr_rdy_o}, 32'h1); step();
      wr_adr_i = 6'd3; wr_dat_i = 20'h33333;
      rd_adr_i = 6'd12; exp_q.push_back(20'h0);
      smp(); chk("bp_c2_wr_rdy", {31'h0, wr_rdy_o}, 32'h0); step();
      rd_adr_i = 6'd13; exp_q.push_back(20'h0);
      smp(); chk("bp_c3_wr_rdy", {31'h0, wr_rdy_o}, 32'h0); step();
      rd_req_i = 1'b0;
      smp();
      chk("bp_c4_wr_rdy", {31'h0, wr_rdy_o}, 32'h0);
      chk("bp_c4_ram", {ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o}, {2'b00, 6'd1, 20'h11111});
      step();
      smp();
      chk("bp_c5_wr_rdy", {31'h0, wr_rdy_o}, 32'h1);
      chk("bp_c5_ram", {ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o}, {2'b00, 6'd2, 20'h22222});
      step();
      wr_val_i = 1'b0;
      smp();
      chk("bp_c6_ram", {ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o}, {2'b00, 6'd3, 20'h33333});
      step();
      smp(); chk("bp_c7_cen", {31'h0, ram_cen_o}, 32'h1); step();
      do_read(6'd1, 20'h11111);
      do_read(6'd2, 20'h22222);
      do_read(6'd3, 20'h33333);

      // Restart with two writes still buffered and a read in flight
      wr_val_i = 1'b1; wr_adr_i = 6'd7; wr_dat_i = 20'h77777;
      rd_req_i = 1'b1; rd_adr_i = 6'd20; exp_q.push_back(20'h0);
      step();
      wr_adr_i = 6'd8; wr_dat_i = 20'h88888;
      rd_adr_i = 6'd21; exp_q.push_back(20'h0);
      smp(); chk("rs_wr_rdy", {31'h0, wr_rdy_o}, 32'h1);
      step();
      idle_inputs();
      run_clear(1'b0);
      do_read(6'd7, 20'h0);
      do_read(6'd8, 20'h0);
      do_read(6'd5, 20'h0);

      // Reset in the middle of a clear
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (30) step();
      chk("mid_clr_adr", {26'h0, ram_adr_o}, 32'd30);
      chk("mid_clr_busy", {31'h0, busy_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         smp();
         chk("post_rst_cen", {31'h0, ram_cen_o}, 32'h1);
         chk("post_rst_busy", {31'h0, busy_o}, 32'h0);
      end
      step();

      chk("rd_outstanding", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
